// File: rtl/instruction_memory_pipelined.sv
// Byte-addressed, little-endian instruction memory with a registered fetch
// port and a word-wide programming port.
//
// The fetch result is registered, so an instruction appears one cycle after
// fetch_req. The output register holds during stall and clears to a NOP on
// flush. A fetch that is out of range, or misaligned when alignment checking
// is enabled, produces a valid NOP with fetch_fault set. A programming write
// in the same cycle as a fetch is forwarded into the fetched word
// (write-first).
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   fetch_req           fetch from Inst_Address this cycle
//   stall, flush        hold outputs / discard the instruction in flight
//   Inst_Address        fetch byte address
//   prog_we/addr/data   word write; prog_data[7:0] goes to byte prog_addr
//   Instruction         registered fetched word (NOP_WORD when not valid)
//   inst_valid          Instruction holds a fetched word or a fault NOP
//   fetch_fault         the fetch behind the current output faulted
module instruction_memory_pipelined #(
  parameter int          ADDR_WIDTH  = 64,
  parameter int          DEPTH_BYTES = 256,
  parameter bit          ALIGN_CHECK = 1'b1,
  parameter logic [31:0] NOP_WORD    = 32'h00000013
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  fetch_req,
  input  logic                  stall,
  input  logic                  flush,
  input  logic [ADDR_WIDTH-1:0] Inst_Address,
  input  logic                  prog_we,
  input  logic [ADDR_WIDTH-1:0] prog_addr,
  input  logic [31:0]           prog_data,
  output logic [31:0]           Instruction,
  output logic                  inst_valid,
  output logic                  fetch_fault
);

  localparam int IW = $clog2(DEPTH_BYTES);
  localparam logic [ADDR_WIDTH-1:0] LAST_WORD = ADDR_WIDTH'(DEPTH_BYTES - 4);

  typedef logic [7:0] mem_t [DEPTH_BYTES];

  // Power-up contents: NOP_WORD in every word. Reset never touches this.
  function automatic mem_t init_mem();
    mem_t m;
    for (int i = 0; i < DEPTH_BYTES; i++) m[i] = NOP_WORD[8*(i%4) +: 8];
    return m;
  endfunction

  mem_t mem = init_mem();

  logic          rd_ok, wr_ok;
  logic [IW-1:0] rd_idx, wr_idx;
  logic [3:0][7:0] rd_bytes;

  // Full-width compares: an address beyond the array must never alias back
  // into it through truncation. Indices are only meaningful once these pass,
  // so idx+3 cannot overflow.
  assign rd_ok  = (Inst_Address <= LAST_WORD) &&
                  !(ALIGN_CHECK && (Inst_Address[1:0] != 2'b00));
  assign wr_ok  = prog_we && !reset && (prog_addr <= LAST_WORD) &&
                  (prog_addr[1:0] == 2'b00);
  assign rd_idx = Inst_Address[IW-1:0];
  assign wr_idx = prog_addr[IW-1:0];

  // One lane per fetched byte; a lane whose byte address falls inside the
  // word being written this cycle takes the write data instead of the array.
  for (genvar k = 0; k < 4; k++) begin : g_lane
    logic [IW-1:0] ra;
    logic [IW-1:0] wdiff;
    logic          hit;
    assign ra       = rd_idx + IW'(k);
    assign wdiff    = ra - wr_idx;
    assign hit      = wr_ok && (ra >= wr_idx) && ((wdiff >> 2) == '0);
    assign rd_bytes[k] = hit ? prog_data[{wdiff[1:0], 3'b000} +: 8] : mem[ra];
  end

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      for (int k = 0; k < 4; k++) mem[wr_idx + IW'(k)] <= prog_data[8*k +: 8];
    end
  end

  // Output register: reset > flush > stall > fetch_req.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      Instruction <= NOP_WORD;
      inst_valid  <= 1'b0;
      fetch_fault <= 1'b0;
    end else if (!stall) begin
      if (fetch_req) begin
        Instruction <= rd_ok ? rd_bytes : NOP_WORD;
        inst_valid  <= 1'b1;
        fetch_fault <= !rd_ok;
      end else begin
        Instruction <= NOP_WORD;
        inst_valid  <= 1'b0;
        fetch_fault <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_instruction_memory_pipelined.sv
// Bench for instruction_memory_pipelined: two instances share every input,
// one with alignment checking and one allowing byte-granular fetch.
module tb_instruction_memory_pipelined;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  logic        reset, fetch_req, stall, flush, prog_we;
  logic [63:0] Inst_Address, prog_addr;
  logic [31:0] prog_data;
  logic [31:0] a_inst, n_inst;
  logic        a_valid, a_fault, n_valid, n_fault;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  instruction_memory_pipelined #(.ALIGN_CHECK(1'b1)) dut (
    .clk(clk), .reset(reset), .fetch_req(fetch_req), .stall(stall), .flush(flush),
    .Inst_Address(Inst_Address), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data), .Instruction(a_inst), .inst_valid(a_valid),
    .fetch_fault(a_fault));

  instruction_memory_pipelined #(.ALIGN_CHECK(1'b0)) dut_na (
    .clk(clk), .reset(reset), .fetch_req(fetch_req), .stall(stall), .flush(flush),
    .Inst_Address(Inst_Address), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data), .Instruction(n_inst), .inst_valid(n_valid),
    .fetch_fault(n_fault));

  // ---------------- reference model ----------------
  logic [7:0]  ref_mem [256];
  logic [31:0] m_inst, mn_inst;
  logic        m_valid, m_fault, mn_fault;

  function automatic void fetch_model(input logic [63:0] a, input bit chk,
                                      output logic [31:0] w, output logic f);
    if (a > 64'd252 || (chk && a[1:0] != 2'b00)) begin
      w = NOP; f = 1'b1;
    end else begin
      w = {ref_mem[int'(a)+3], ref_mem[int'(a)+2], ref_mem[int'(a)+1], ref_mem[int'(a)]};
      f = 1'b0;
    end
  endfunction

  task automatic model_step();
    if (reset) begin
      m_inst = NOP; m_valid = 0; m_fault = 0; mn_inst = NOP; mn_fault = 0;
    end else begin
      if (prog_we && prog_addr <= 64'd252 && prog_addr[1:0] == 2'b00)
        for (int k = 0; k < 4; k++) ref_mem[int'(prog_addr)+k] = prog_data[8*k +: 8];
      if (flush) begin
        m_inst = NOP; m_valid = 0; m_fault = 0; mn_inst = NOP; mn_fault = 0;
      end else if (!stall) begin
        if (fetch_req) begin
          fetch_model(Inst_Address, 1'b1, m_inst, m_fault);
          fetch_model(Inst_Address, 1'b0, mn_inst, mn_fault);
          m_valid = 1;
        end else begin
          m_inst = NOP; m_valid = 0; m_fault = 0; mn_inst = NOP; mn_fault = 0;
        end
      end
    end
  endtask

  // Advance one clock; the model sees the same inputs the DUT sampled.
  task automatic run_cycle();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] ai, input logic av,
                       input logic af, input logic [31:0] ei, input logic ev,
                       input logic ef);
    checks++;
    if (ai !== ei || av !== ev || af !== ef) begin
      errors++;
      $display("FAIL %s: got inst=%h valid=%b fault=%b, want inst=%h valid=%b fault=%b",
               name, ai, av, af, ei, ev, ef);
    end
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    string       name;
    logic        rst, fr, st, fl;
    logic [63:0] addr;
    logic        we;
    logic [63:0] pa;
    logic [31:0] pd;
    logic [31:0] ei;
    logic        ev, ef;
    logic [31:0] ni;
    logic        nf;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(string nm, logic rst, logic fr, logic st, logic fl,
                              logic [63:0] addr, logic we, logic [63:0] pa,
                              logic [31:0] pd, logic [31:0] ei, logic ev, logic ef);
    vec_t v;
    v.name = nm; v.rst = rst; v.fr = fr; v.st = st; v.fl = fl; v.addr = addr;
    v.we = we; v.pa = pa; v.pd = pd; v.ei = ei; v.ev = ev; v.ef = ef;
    v.ni = ei; v.nf = ef;
    return v;
  endfunction

  function automatic logic [63:0] rand_addr();
    case ($urandom_range(0, 9))
      0, 1:    return {32'hFFFF_FFFF, 30'($urandom), 2'b00};
      2, 3:    return 64'($urandom_range(244, 264));
      4, 5:    return 64'($urandom_range(0, 255));
      default: return 64'($urandom_range(0, 63) * 4);
    endcase
  endfunction

  initial begin
    vec_t v;
    for (int i = 0; i < 256; i++) ref_mem[i] = NOP[8*(i%4) +: 8];
    m_inst = NOP; m_valid = 0; m_fault = 0; mn_inst = NOP; mn_fault = 0;

    //              name          rst fr st fl addr                    we pa       pd            exp inst     v  f
    tbl.push_back(mk("rst0",       1, 0, 0, 0, 64'h0,                  0, 64'h0,   32'h0,        NOP,          0, 0));
    tbl.push_back(mk("rst1",       1, 1, 0, 0, 64'h1C,                 1, 64'h0,   32'hAAAA5555, NOP,          0, 0));
    tbl.push_back(mk("idle_w20",   0, 0, 0, 0, 64'h0,                  1, 64'h20,  32'h44332211, NOP,          0, 0));
    tbl.push_back(mk("idle_w1c",   0, 0, 0, 0, 64'h0,                  1, 64'h1C,  32'h00128293, NOP,          0, 0));
    tbl.push_back(mk("fetch_1c",   0, 1, 0, 0, 64'h1C,                 0, 64'h0,   32'h0,        32'h00128293, 1, 0));
    tbl.push_back(mk("coll_7c",    0, 1, 0, 0, 64'h7C,                 1, 64'h7C,  32'hFEB346E3, 32'hFEB346E3, 1, 0));
    tbl.push_back(mk("strm_78",    0, 1, 0, 0, 64'h78,                 1, 64'hFC,  32'hDEADBEEF, NOP,          1, 0));
    tbl.push_back(mk("strm_7c",    0, 1, 0, 0, 64'h7C,                 0, 64'h0,   32'h0,        32'hFEB346E3, 1, 0));
    tbl.push_back(mk("fetch_fc",   0, 1, 0, 0, 64'hFC,                 0, 64'h0,   32'h0,        32'hDEADBEEF, 1, 0));
    tbl.push_back(mk("oob_100",    0, 1, 0, 0, 64'h100,                1, 64'h24,  32'h88776655, NOP,          1, 1));
    tbl.push_back(mk("oob_top",    0, 1, 0, 0, 64'hFFFF_FFFF_FFFF_FFFC, 0, 64'h0,  32'h0,        NOP,          1, 1));
    v = mk("mis_22",               0, 1, 0, 0, 64'h22,                 0, 64'h0,   32'h0,        NOP,          1, 1);
    v.ni = 32'h66554433; v.nf = 1'b0;
    tbl.push_back(v);
    tbl.push_back(mk("fetch_1c_b", 0, 1, 0, 0, 64'h1C,                 0, 64'h0,   32'h0,        32'h00128293, 1, 0));
    tbl.push_back(mk("stall0",     0, 1, 1, 0, 64'h40,                 0, 64'h0,   32'h0,        32'h00128293, 1, 0));
    tbl.push_back(mk("stall1",     0, 1, 1, 0, 64'h22,                 0, 64'h0,   32'h0,        32'h00128293, 1, 0));
    tbl.push_back(mk("stall2",     0, 1, 1, 0, 64'h100,                0, 64'h0,   32'h0,        32'h00128293, 1, 0));
    tbl.push_back(mk("stall_flush",0, 1, 1, 1, 64'h1C,                 0, 64'h0,   32'h0,        NOP,          0, 0));
    tbl.push_back(mk("fetch_7c",   0, 1, 0, 0, 64'h7C,                 0, 64'h0,   32'h0,        32'hFEB346E3, 1, 0));
    tbl.push_back(mk("rst_mid",    1, 1, 0, 0, 64'h78,                 1, 64'h1C,  32'h12345678, NOP,          0, 0));
    tbl.push_back(mk("post_rst",   0, 1, 0, 0, 64'h1C,                 0, 64'h0,   32'h0,        32'h00128293, 1, 0));
    tbl.push_back(mk("idle_wmis",  0, 0, 0, 0, 64'h0,                  1, 64'h1E,  32'hFFFFFFFF, NOP,          0, 0));
    tbl.push_back(mk("chk_wmis",   0, 1, 0, 0, 64'h1C,                 1, 64'h100, 32'hFFFFFFFF, 32'h00128293, 1, 0));
    tbl.push_back(mk("chk_woob",   0, 1, 0, 0, 64'h0,                  0, 64'h0,   32'h0,        NOP,          1, 0));
    tbl.push_back(mk("flush",      0, 1, 0, 1, 64'h1C,                 0, 64'h0,   32'h0,        NOP,          0, 0));

    foreach (tbl[i]) begin
      reset = tbl[i].rst; fetch_req = tbl[i].fr; stall = tbl[i].st; flush = tbl[i].fl;
      Inst_Address = tbl[i].addr; prog_we = tbl[i].we; prog_addr = tbl[i].pa;
      prog_data = tbl[i].pd;
      run_cycle();
      check(tbl[i].name, a_inst, a_valid, a_fault, tbl[i].ei, tbl[i].ev, tbl[i].ef);
      check({tbl[i].name, "_na"}, n_inst, n_valid, n_fault, tbl[i].ni, tbl[i].ev, tbl[i].nf);
    end

    // Randomized traffic against the reference model.
    for (int c = 0; c < 400; c++) begin
      reset        = ($urandom_range(0, 39) == 0);
      flush        = ($urandom_range(0, 7) == 0);
      stall        = ($urandom_range(0, 5) == 0);
      fetch_req    = ($urandom_range(0, 3) != 0);
      Inst_Address = rand_addr();
      prog_we      = ($urandom_range(0, 2) == 0);
      prog_addr    = ($urandom_range(0, 3) == 0) ? (Inst_Address & ~64'h3) : rand_addr();
      prog_data    = $urandom;
      run_cycle();
      check("rand", a_inst, a_valid, a_fault, m_inst, m_valid, m_fault);
      check("rand_na", n_inst, n_valid, n_fault, mn_inst, m_valid, mn_fault);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instruction_memory_pipelined.md
Name: instruction_memory_pipelined

Overview:
Parametrised, byte-addressed, little-endian instruction memory with a registered read port and a word-wide programming port. It replaces the purely combinational fetch memory. It sits between the PC register and the IF/ID pipeline register, and adds one-cycle fetch latency, stall/flush control, bounds and alignment fault reporting, and run-time program loading by the testbench or a boot loader.

Parameters:
ADDR_WIDTH, 64, width of the fetch and program addresses (byte addresses)
DEPTH_BYTES, 256, memory size in bytes; must be a multiple of 4 and at least 4
ALIGN_CHECK, 1, 1 = fetch address with addr[1:0] != 0 faults; 0 = unaligned byte-granular fetch allowed
NOP_WORD, 32'h00000013, value driven on Instruction when no valid instruction is present (addi x0,x0,0)

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
fetch_req  input  1  request a fetch from Inst_Address this cycle
stall  input  1  hold all outputs unchanged (pipeline stall)
flush  input  1  discard the instruction in flight (branch taken)
Inst_Address  input  ADDR_WIDTH  fetch byte address
prog_we  input  1  write enable for the programming port
prog_addr  input  ADDR_WIDTH  program byte address; must be word-aligned
prog_data  input  32  program word; bits [7:0] go to byte prog_addr
Instruction  output  32  fetched instruction, registered
inst_valid  output  1  Instruction holds a fetched word (or a fault NOP)
fetch_fault  output  1  the fetch that produced the current output was out of range or misaligned

Behaviour:
- Storage: DEPTH_BYTES x 8-bit array, little-endian. Word at address A = {mem[A+3], mem[A+2], mem[A+1], mem[A]}.
- Initialisation: at time 0 every byte pattern equals NOP_WORD repeated per word. reset does NOT clear memory contents.
- Reset (synchronous, rising edge with reset=1): Instruction=NOP_WORD, inst_valid=0, fetch_fault=0. Writes and fetch_req are ignored in that cycle.
- Control priority per cycle: reset > flush > stall > fetch_req.
- flush=1: next cycle Instruction=NOP_WORD, inst_valid=0, fetch_fault=0. This holds even if stall or fetch_req is also high.
- stall=1 (no flush): Instruction, inst_valid and fetch_fault keep their values. A fetch_req in that cycle is dropped, not queued.
- fetch_req=1 (no stall/flush): latency is 1 cycle. On the next edge inst_valid=1 and Instruction/fetch_fault are updated as follows:
  - In range and aligned: Instruction = word at Inst_Address, fetch_fault=0.
  - Out of range: condition is Inst_Address > DEPTH_BYTES-4, using a full ADDR_WIDTH comparison with no truncation and no wrap-around. Result: Instruction=NOP_WORD, fetch_fault=1.
  - Misaligned: condition is ALIGN_CHECK=1 and Inst_Address[1:0]!=0. Result: Instruction=NOP_WORD, fetch_fault=1.
- fetch_req=0 (no stall/flush): next cycle inst_valid=0, Instruction=NOP_WORD, fetch_fault=0.
- Programming port:
  - prog_we=1 writes 4 bytes at prog_addr on the rising edge.
  - Ignored when prog_addr > DEPTH_BYTES-4 or prog_addr[1:0]!=0; no error output.
  - Writes are independent of stall/flush and blocked only by reset.
- Read/write collision: same-cycle fetch and write whose byte ranges overlap is write-first. The fetched word reflects prog_data for the overlapping bytes.
- Back-to-back fetches: one instruction per cycle, no bubbles.
- Address arithmetic: A+1..A+3 are computed only after the range check passes, so there is no index overflow at the top of the address space.

Test Plan:
- Reset then idle: assert reset 2 cycles, release, fetch_req=0 -> Instruction=32'h00000013, inst_valid=0, fetch_fault=0.
- Program and fetch: prog_we writes 32'h00128293 at 0x1C; next cycle fetch_req with Inst_Address=0x1C -> one cycle later Instruction=32'h00128293, inst_valid=1.
- Collision and streaming: write 32'hFEB346E3 to 0x7C while fetching 0x7C in the same cycle -> Instruction=32'hFEB346E3. Fetching 0x78 then 0x7C on consecutive cycles -> two valid outputs on consecutive cycles.
- Faults (DEPTH_BYTES=256):
  - Fetch 0xFC -> valid word, fault=0.
  - Fetch 0x100 -> NOP, fault=1, valid=1.
  - Fetch 0xFFFF_FFFF_FFFF_FFFC -> NOP, fault=1.
  - Fetch 0x22 with ALIGN_CHECK=1 -> NOP, fault=1.
  - Fetch 0x22 with ALIGN_CHECK=0 -> bytes 0x25..0x22, fault=0.
- Stall/flush: fetch 0x1C, then hold stall 3 cycles while Inst_Address changes -> output stays at the 0x1C word. Assert flush together with stall -> next cycle inst_valid=0, Instruction=NOP.
- Reset mid-operation: assert reset during a streaming fetch with prog_we=1 -> outputs return to reset values and the write is not performed. Previously programmed words are still readable after reset.
